// File: rtl/mul4_eval_pkg.sv
// Shared definitions for the mul4 candidate evaluation harness:
// FSM encoding, stimulus constants and a bit-count helper.
package mul4_eval_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRIVE = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // Fibonacci feedback taps 64,63,61,60 expressed as bit positions 63,62,60,59
   localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

   // Fixed corner vectors, packed as {a, b}
   localparam logic [63:0] VEC0_AB = 64'h0000_0000_0000_0000;
   localparam logic [63:0] VEC1_AB = 64'hFFFF_FFFF_FFFF_FFFF;

   function automatic logic [6:0] popcount64(input logic [63:0] v);
      logic [6:0] n;
      n = '0;
      for (int i = 0; i < 64; i++) begin
         n = n + 7'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/mul4_lfsr64.sv
// 64-bit Fibonacci LFSR stimulus source with explicit reload and advance.
// A zero seed would lock the register at zero, so it is promoted to 1.
module mul4_lfsr64
   import mul4_eval_pkg::*;
#(
   parameter logic [63:0] SEED = 64'h0000_0000_0000_0001
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_load,
   input  logic        i_advance,
   output logic [63:0] o_state
);

   localparam logic [63:0] SEED_NZ = (SEED == 64'h0) ? 64'h1 : SEED;

   logic [63:0] r_state;
   logic        w_fb;

   assign w_fb    = ^(r_state & LFSR_TAPS);
   assign o_state = r_state;

   // Reload on reset or run start, otherwise shift one step per advance
   always_ff @(posedge clk) begin
      if (!rst_n || i_load) begin
         r_state <= SEED_NZ;
      end else if (i_advance) begin
         r_state <= {r_state[62:0], w_fb};
      end
   end

endmodule

// File: rtl/mul4_fitness_scorer.sv
// Sequential fitness harness around one combinational mul4 candidate.
// Drives one operand vector per cycle, registers per-vector bit/word
// hit counts against the golden 32x32->64 product, and accumulates them.
module mul4_fitness_scorer
   import mul4_eval_pkg::*;
#(
   parameter int          NUM_VECTORS = 256,
   parameter logic [63:0] SEED        = 64'hACE1_5EED_0BAD_F00D,
   parameter int          SCORE_W     = $clog2(NUM_VECTORS*64+1),
   parameter int          WORD_W      = $clog2(NUM_VECTORS*4+1)
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   output logic [15:0]        a1,
   output logic [15:0]        a0,
   output logic [15:0]        b1,
   output logic [15:0]        b0,
   input  logic [15:0]        y3,
   input  logic [15:0]        y2,
   input  logic [15:0]        y1,
   input  logic [15:0]        y0,
   output logic               busy,
   output logic               done,
   output logic [SCORE_W-1:0] bit_score,
   output logic [WORD_W-1:0]  word_score,
   output logic               perfect
);

   localparam int                  IDX_W      = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;
   localparam logic [IDX_W-1:0]    LAST_IDX   = IDX_W'(NUM_VECTORS - 1);
   localparam logic [SCORE_W-1:0]  FULL_SCORE = SCORE_W'(NUM_VECTORS * 64);

   // Number of 16-bit lanes where candidate and golden agree exactly
   function automatic logic [2:0] lane_matches(input logic [63:0] y, input logic [63:0] g);
      logic [2:0] n;
      n = '0;
      for (int l = 0; l < 4; l++) begin
         if (y[l*16 +: 16] == g[l*16 +: 16]) n = n + 3'd1;
      end
      return n;
   endfunction

   state_t             r_state;
   logic [31:0]        r_a;
   logic [31:0]        r_b;
   logic [IDX_W-1:0]   r_idx;
   logic               r_busy;
   logic               r_done;
   logic               r_perfect;
   logic [SCORE_W-1:0] r_bit_score;
   logic [WORD_W-1:0]  r_word_score;
   logic               r_vld_p1;
   logic [6:0]         r_bit_hits_p1;
   logic [2:0]         r_word_hits_p1;

   logic [63:0]        w_golden;
   logic [63:0]        w_y;
   logic [6:0]         w_bit_hits;
   logic [2:0]         w_word_hits;
   logic [63:0]        w_lfsr_state;
   logic               w_lfsr_load;
   logic               w_lfsr_adv;
   logic               w_start_ok;
   logic [SCORE_W-1:0] w_bit_sum;
   logic [WORD_W-1:0]  w_word_sum;

   assign a1 = r_a[31:16];
   assign a0 = r_a[15:0];
   assign b1 = r_b[31:16];
   assign b0 = r_b[15:0];

   assign busy       = r_busy;
   assign done       = r_done;
   assign bit_score  = r_bit_score;
   assign word_score = r_word_score;
   assign perfect    = r_perfect;

   assign w_y         = {y3, y2, y1, y0};
   assign w_golden    = {32'h0, r_a} * {32'h0, r_b};
   assign w_bit_hits  = popcount64(~(w_y ^ w_golden));
   assign w_word_hits = lane_matches(w_y, w_golden);

   assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_lfsr_load = w_start_ok;
   // Vector 2 consumes the freshly loaded state; each later vector steps once
   assign w_lfsr_adv  = (r_state == S_DRIVE) && (r_idx != LAST_IDX) && (r_idx != '0);

   assign w_bit_sum  = r_bit_score  + SCORE_W'(r_bit_hits_p1);
   assign w_word_sum = r_word_score + WORD_W'(r_word_hits_p1);

   mul4_lfsr64 #(
      .SEED      (SEED)
   ) u_lfsr (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_load    (w_lfsr_load),
      .i_advance (w_lfsr_adv),
      .o_state   (w_lfsr_state)
   );

   // Score stage: capture hit counts of the vector currently on the operands
   always_ff @(posedge clk) begin
      r_bit_hits_p1  <= w_bit_hits;
      r_word_hits_p1 <= w_word_hits;
   end

   // Run control: vector sequencing, accumulation and result flags
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_a          <= '0;
         r_b          <= '0;
         r_idx        <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_perfect    <= 1'b0;
         r_bit_score  <= '0;
         r_word_score <= '0;
         r_vld_p1     <= 1'b0;
      end else begin
         r_vld_p1 <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_bit_score  <= '0;
                  r_word_score <= '0;
                  r_perfect    <= 1'b0;
                  r_done       <= 1'b0;
                  r_busy       <= 1'b1;
                  r_idx        <= '0;
                  {r_a, r_b}   <= VEC0_AB;
                  r_state      <= S_DRIVE;
               end
            end
            S_DRIVE: begin
               r_vld_p1 <= 1'b1;
               if (r_vld_p1) begin
                  r_bit_score  <= w_bit_sum;
                  r_word_score <= w_word_sum;
               end
               if (r_idx == LAST_IDX) begin
                  r_state <= S_DRAIN;
               end else begin
                  r_idx <= r_idx + 1'b1;
                  if (r_idx == '0) begin
                     {r_a, r_b} <= VEC1_AB;
                  end else begin
                     {r_a, r_b} <= w_lfsr_state;
                  end
               end
            end
            S_DRAIN: begin
               r_bit_score  <= w_bit_sum;
               r_word_score <= w_word_sum;
               r_perfect    <= (w_bit_sum == FULL_SCORE);
               r_busy       <= 1'b0;
               r_done       <= 1'b1;
               r_state      <= S_DONE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mul4_fitness_scorer.sv
// Directed bench for mul4_fitness_scorer: three harness instances with
// different vector counts and seeds, each wrapped around a bench-side
// candidate model (exact product, constant zero, or OR-only individual).
module tb_mul4_fitness_scorer;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Candidate models: 0 = exact product, 1 = tied to zero, 2 = OR-only
   function automatic logic [63:0] cand(input int m, input logic [15:0] a1, input logic [15:0] a0,
                                        input logic [15:0] b1, input logic [15:0] b0);
      case (m)
         0:       return {32'h0, a1, a0} * {32'h0, b1, b0};
         1:       return 64'h0;
         default: return {16'h0, b1 | a1, a1, a0};
      endcase
   endfunction

   // 256-vector instance, default seed
   int          mode_g;
   logic        start_g;
   logic [15:0] a1_g, a0_g, b1_g, b0_g, y3_g, y2_g, y1_g, y0_g;
   logic        busy_g, done_g, perf_g;
   logic [14:0] bits_g;
   logic [10:0] words_g;
   assign {y3_g, y2_g, y1_g, y0_g} = cand(mode_g, a1_g, a0_g, b1_g, b0_g);

   mul4_fitness_scorer #(.NUM_VECTORS(256)) u_big (
      .clk(clk), .rst_n(rst_n), .start(start_g),
      .a1(a1_g), .a0(a0_g), .b1(b1_g), .b0(b0_g),
      .y3(y3_g), .y2(y2_g), .y1(y1_g), .y0(y0_g),
      .busy(busy_g), .done(done_g), .bit_score(bits_g), .word_score(words_g), .perfect(perf_g)
   );

   // 2-vector instance
   int          mode_t;
   logic        start_t;
   logic [15:0] a1_t, a0_t, b1_t, b0_t, y3_t, y2_t, y1_t, y0_t;
   logic        busy_t, done_t, perf_t;
   logic [7:0]  bits_t;
   logic [3:0]  words_t;
   assign {y3_t, y2_t, y1_t, y0_t} = cand(mode_t, a1_t, a0_t, b1_t, b0_t);

   mul4_fitness_scorer #(.NUM_VECTORS(2)) u_two (
      .clk(clk), .rst_n(rst_n), .start(start_t),
      .a1(a1_t), .a0(a0_t), .b1(b1_t), .b0(b0_t),
      .y3(y3_t), .y2(y2_t), .y1(y1_t), .y0(y0_t),
      .busy(busy_t), .done(done_t), .bit_score(bits_t), .word_score(words_t), .perfect(perf_t)
   );

   // 8-vector instance with a zero seed
   logic        start_s;
   logic [15:0] a1_s, a0_s, b1_s, b0_s, y3_s, y2_s, y1_s, y0_s;
   logic        busy_s, done_s, perf_s;
   logic [9:0]  bits_s;
   logic [5:0]  words_s;
   assign {y3_s, y2_s, y1_s, y0_s} = cand(0, a1_s, a0_s, b1_s, b0_s);

   mul4_fitness_scorer #(.NUM_VECTORS(8), .SEED(64'h0)) u_s0 (
      .clk(clk), .rst_n(rst_n), .start(start_s),
      .a1(a1_s), .a0(a0_s), .b1(b1_s), .b0(b0_s),
      .y3(y3_s), .y2(y2_s), .y1(y1_s), .y0(y0_s),
      .busy(busy_s), .done(done_s), .bit_score(bits_s), .word_score(words_s), .perfect(perf_s)
   );

   logic [63:0] seq_buf [256];
   logic [63:0] seq_ref [256];
   logic [63:0] seq_s0  [8];

   task automatic run_big(input int budget, output int cyc);
      start_g = 1'b1;
      @(posedge clk); #1;
      start_g = 1'b0;
      cyc = 0;
      seq_buf[0] = {a1_g, a0_g, b1_g, b0_g};
      while (done_g !== 1'b1 && cyc < budget) begin
         @(posedge clk); #1;
         cyc++;
         if (cyc < 256) seq_buf[cyc] = {a1_g, a0_g, b1_g, b0_g};
      end
   endtask

   task automatic run_two(input int budget, output int cyc);
      start_t = 1'b1;
      @(posedge clk); #1;
      start_t = 1'b0;
      cyc = 0;
      while (done_t !== 1'b1 && cyc < budget) begin
         @(posedge clk); #1;
         cyc++;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if ({a1_g, a0_g, b1_g, b0_g, busy_g, done_g, perf_g, bits_g, words_g} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: got a=%h b=%h busy=%b done=%b perf=%b bits=%0d words=%0d, want all 0",
                  {a1_g, a0_g}, {b1_g, b0_g}, busy_g, done_g, perf_g, bits_g, words_g);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (busy_g !== 1'b0 || done_g !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy_g, done_g);
      end
   endtask

   task automatic test_perfect;
      int cyc;
      mode_g = 0;
      run_big(400, cyc);
      for (int i = 0; i < 256; i++) seq_ref[i] = seq_buf[i];
      n_cmp++;
      if (cyc != 257) begin
         n_bad++; $display("FAIL perfect_latency: got %0d cycles, want 257", cyc);
      end
      n_cmp++;
      if (bits_g !== 15'd16384 || words_g !== 11'd1024 || perf_g !== 1'b1 || busy_g !== 1'b0) begin
         n_bad++;
         $display("FAIL perfect_scores: got bits=%0d words=%0d perf=%b busy=%b, want 16384 1024 1 0",
                  bits_g, words_g, perf_g, busy_g);
      end
      n_cmp++;
      if (seq_buf[0] !== 64'h0 || seq_buf[1] !== 64'hFFFF_FFFF_FFFF_FFFF) begin
         n_bad++; $display("FAIL fixed_vectors: got v0=%h v1=%h, want 0 and all ones", seq_buf[0], seq_buf[1]);
      end
      n_cmp++;
      if (seq_buf[2] !== 64'hACE1_5EED_0BAD_F00D || seq_buf[3] !== 64'h59C2_BDDA_175B_E01A) begin
         n_bad++;
         $display("FAIL lfsr_vectors: got v2=%h v3=%h, want ace15eed0badf00d 59c2bdda175be01a",
                  seq_buf[2], seq_buf[3]);
      end
      n_cmp++;
      if ({a1_g, a0_g, b1_g, b0_g} !== seq_buf[255]) begin
         n_bad++; $display("FAIL done_hold_operands: got %h, want %h", {a1_g, a0_g, b1_g, b0_g}, seq_buf[255]);
      end
   endtask

   task automatic test_start_ignored;
      int cyc;
      mode_g = 0;
      start_g = 1'b1;
      @(posedge clk); #1;
      start_g = 1'b0;
      cyc = 0;
      while (done_g !== 1'b1 && cyc < 400) begin
         start_g = (cyc == 3 || cyc == 10);
         @(posedge clk); #1;
         start_g = 1'b0;
         cyc++;
         if (cyc == 5) begin
            n_cmp++;
            if (bits_g !== 15'd256 || busy_g !== 1'b1) begin
               n_bad++; $display("FAIL midrun_partial: got bits=%0d busy=%b, want 256 1", bits_g, busy_g);
            end
         end
      end
      n_cmp++;
      if (cyc != 257 || bits_g !== 15'd16384 || words_g !== 11'd1024 || perf_g !== 1'b1) begin
         n_bad++;
         $display("FAIL start_ignored: got cyc=%0d bits=%0d words=%0d perf=%b, want 257 16384 1024 1",
                  cyc, bits_g, words_g, perf_g);
      end
   endtask

   task automatic test_zero_candidate;
      int cyc;
      mode_t = 1;
      run_two(20, cyc);
      n_cmp++;
      if (cyc != 3 || bits_t !== 8'd96 || words_t !== 4'd5 || perf_t !== 1'b0) begin
         n_bad++;
         $display("FAIL zero_candidate: got cyc=%0d bits=%0d words=%0d perf=%b, want 3 96 5 0",
                  cyc, bits_t, words_t, perf_t);
      end
   endtask

   task automatic test_or_candidate;
      int cyc;
      mode_t = 2;
      run_two(20, cyc);
      n_cmp++;
      if (cyc != 3 || bits_t !== 8'd80 || words_t !== 4'd4 || perf_t !== 1'b0) begin
         n_bad++;
         $display("FAIL or_candidate: got cyc=%0d bits=%0d words=%0d perf=%b, want 3 80 4 0",
                  cyc, bits_t, words_t, perf_t);
      end
   endtask

   task automatic test_back_to_back;
      int cyc;
      mode_t = 1;
      start_t = 1'b1;
      @(posedge clk); #1;
      start_t = 1'b0;
      n_cmp++;
      if (done_t !== 1'b0 || busy_t !== 1'b1 || bits_t !== 8'd0 || {a1_t, a0_t, b1_t, b0_t} !== 64'h0) begin
         n_bad++;
         $display("FAIL b2b_restart: got done=%b busy=%b bits=%0d ops=%h, want 0 1 0 0",
                  done_t, busy_t, bits_t, {a1_t, a0_t, b1_t, b0_t});
      end
      cyc = 0;
      while (done_t !== 1'b1 && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      n_cmp++;
      if (cyc != 3 || bits_t !== 8'd96 || words_t !== 4'd5 || perf_t !== 1'b0) begin
         n_bad++;
         $display("FAIL b2b_scores: got cyc=%0d bits=%0d words=%0d perf=%b, want 3 96 5 0",
                  cyc, bits_t, words_t, perf_t);
      end
   endtask

   task automatic test_seed_zero;
      int cyc;
      int bad_vec;
      start_s = 1'b1;
      @(posedge clk); #1;
      start_s = 1'b0;
      cyc = 0;
      seq_s0[0] = {a1_s, a0_s, b1_s, b0_s};
      while (done_s !== 1'b1 && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         if (cyc < 8) seq_s0[cyc] = {a1_s, a0_s, b1_s, b0_s};
      end
      n_cmp++;
      if (seq_s0[2] !== 64'h0000_0000_0000_0001) begin
         n_bad++; $display("FAIL seed0_vec2: got %h, want 0000000000000001", seq_s0[2]);
      end
      bad_vec = 0;
      for (int k = 3; k < 8; k++) begin
         if (seq_s0[k] !== (64'd1 << (k - 2))) bad_vec++;
      end
      n_cmp++;
      if (bad_vec != 0) begin
         n_bad++; $display("FAIL seed0_later: got %0d wrong vectors of 5 (v7=%h), want 0 (v7=20)", bad_vec, seq_s0[7]);
      end
      n_cmp++;
      if (cyc != 9 || bits_s !== 10'd512 || words_s !== 6'd32 || perf_s !== 1'b1) begin
         n_bad++;
         $display("FAIL seed0_scores: got cyc=%0d bits=%0d words=%0d perf=%b, want 9 512 32 1",
                  cyc, bits_s, words_s, perf_s);
      end
   endtask

   task automatic test_reset_midrun;
      int cyc;
      int diffs;
      mode_g = 0;
      start_g = 1'b1;
      @(posedge clk); #1;
      start_g = 1'b0;
      cyc = 0;
      while (cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
      end
      n_cmp++;
      if ({a1_g, a0_g, b1_g, b0_g} !== seq_ref[100] || busy_g !== 1'b1) begin
         n_bad++; $display("FAIL midrun_vec100: got %h busy=%b, want %h 1", {a1_g, a0_g, b1_g, b0_g}, busy_g, seq_ref[100]);
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      n_cmp++;
      if ({a1_g, a0_g, b1_g, b0_g, busy_g, done_g, perf_g, bits_g, words_g} !== '0) begin
         n_bad++;
         $display("FAIL midrun_reset: got ops=%h busy=%b done=%b perf=%b bits=%0d words=%0d, want all 0",
                  {a1_g, a0_g, b1_g, b0_g}, busy_g, done_g, perf_g, bits_g, words_g);
      end
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (busy_g !== 1'b0 || bits_g !== 15'd0) begin
         n_bad++; $display("FAIL midrun_idle: got busy=%b bits=%0d, want 0 0", busy_g, bits_g);
      end
      run_big(400, cyc);
      diffs = 0;
      for (int i = 0; i < 256; i++) begin
         if (seq_buf[i] !== seq_ref[i]) diffs++;
      end
      n_cmp++;
      if (diffs != 0) begin
         n_bad++; $display("FAIL rerun_sequence: got %0d differing vectors, want 0", diffs);
      end
      n_cmp++;
      if (cyc != 257 || bits_g !== 15'd16384 || words_g !== 11'd1024 || perf_g !== 1'b1) begin
         n_bad++;
         $display("FAIL rerun_scores: got cyc=%0d bits=%0d words=%0d perf=%b, want 257 16384 1024 1",
                  cyc, bits_g, words_g, perf_g);
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      start_g = 1'b0;
      start_t = 1'b0;
      start_s = 1'b0;
      mode_g  = 0;
      mode_t  = 1;
      test_reset();
      test_perfect();
      test_start_ignored();
      test_zero_candidate();
      test_or_candidate();
      test_back_to_back();
      test_seed_zero();
      test_reset_midrun();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
